// File: rtl/pack_pkg.sv
// pack_pkg
//   Shared types for the stream bank packer.
//   pack_cfg_t   : per-job configuration {words_per_bank, num_fills}
//   pack_state_e : packer control states
//   The struct field widths follow the PACK_* localparams; the top-level
//   BANK_ADDR_WIDTH / FILL_CNT_WIDTH parameters default to these and must match them.
package pack_pkg;

  localparam int PACK_BANK_ADDR_WIDTH = 8;
  localparam int PACK_FILL_CNT_WIDTH  = 16;

  typedef struct packed {
    logic [PACK_BANK_ADDR_WIDTH:0]  words_per_bank;  // one extra bit so a full bank is expressible
    logic [PACK_FILL_CNT_WIDTH-1:0] num_fills;
  } pack_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } pack_state_e;

endpackage

// File: rtl/lane_packer.sv
// lane_packer
//   Collects narrow stream beats into one LANES-wide word.
//   clk, rst     : clock, async active-high reset
//   beat         : a stream word is accepted this cycle (in_dat valid)
//   flush_en     : close the current word early; unfilled lanes read as zero
//   in_dat       : stream word, stored in lane lane_cnt
//   lane_empty   : no lanes currently held
//   word_done    : combinational pulse, word is complete this cycle
//   word         : assembled word (lane 0 in LSBs), valid while word_done=1
module lane_packer
  import pack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        beat,
  input  logic                        flush_en,
  input  logic [DATA_WIDTH-1:0]       in_dat,
  output logic                        lane_empty,
  output logic                        word_done,
  output logic [DATA_WIDTH*LANES-1:0] word
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] lane_cnt_reg;

  assign lane_empty = (lane_cnt_reg == '0);

  // A same-cycle beat is counted before the flush, so a flush that arrives
  // with the first beat of a word still produces that (padded) word.
  assign word_done = (beat && (lane_cnt_reg == LAST_LANE)) ||
                     (flush_en && (beat || !lane_empty));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_reg <= '0;
    end else if (word_done) begin
      lane_cnt_reg <= '0;
    end else if (beat) begin
      lane_cnt_reg <= lane_cnt_reg + CNT_ONE;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
    logic [DATA_WIDTH-1:0] lane_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_reg <= '0;
      end else if (beat && (lane_cnt_reg == IDX)) begin
        lane_reg <= in_dat;
      end
    end

    // Lanes beyond the fill point may hold stale data from the previous
    // word, so they are forced to zero rather than read back.
    assign word[gi*DATA_WIDTH +: DATA_WIDTH] =
      (IDX < lane_cnt_reg)                 ? lane_reg :
      (beat && (IDX == lane_cnt_reg))      ? in_dat   :
                                             '0;
  end

endmodule

// File: rtl/stream_bank_packer.sv
// stream_bank_packer
//   Packs a ready/valid word stream into LANES-wide bank words, writes them
//   into one bank of a double buffer and swaps banks using a reader credit.
//   clk, rst      : clock, async active-high reset
//   cfg_dat/vld/rdy : job configuration handshake (accepted only when idle)
//   in_dat/vld/rdy  : narrow stream handshake
//   flush         : finish the current fill early, zero padding the last word
//   bank_free     : reader released a bank (sets the single credit)
//   wen/wadr/wdata: double-buffer write port
//   switch_banks  : pulse, swap double-buffer banks
//   done          : pulse with the final switch of the job
module stream_bank_packer
  import pack_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int LANES           = 8,
  parameter int BANK_ADDR_WIDTH = PACK_BANK_ADDR_WIDTH,
  parameter int FILL_CNT_WIDTH  = PACK_FILL_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  pack_cfg_t                   cfg_dat,
  input  logic                        cfg_vld,
  output logic                        cfg_rdy,
  input  logic [DATA_WIDTH-1:0]       in_dat,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic                        flush,
  input  logic                        bank_free,
  output logic                        wen,
  output logic [BANK_ADDR_WIDTH-1:0]  wadr,
  output logic [DATA_WIDTH*LANES-1:0] wdata,
  output logic                        switch_banks,
  output logic                        done
);

  localparam int WORD_W = DATA_WIDTH * LANES;
  localparam logic [BANK_ADDR_WIDTH:0]  ADDR_ONE = (BANK_ADDR_WIDTH + 1)'(1);
  localparam logic [FILL_CNT_WIDTH-1:0] FILL_ONE = FILL_CNT_WIDTH'(1);

  pack_state_e                state_reg, state_next;
  logic [BANK_ADDR_WIDTH:0]   addr_cnt_reg, addr_cnt_next;
  logic [BANK_ADDR_WIDTH:0]   wpb_reg, wpb_next;
  logic [FILL_CNT_WIDTH-1:0]  fills_left_reg, fills_left_next;
  logic                       credit_reg, credit_next, consume;
  logic                       cfg_rdy_reg, in_rdy_reg;
  logic                       wen_reg, wen_next;
  logic [BANK_ADDR_WIDTH-1:0] wadr_reg, wadr_next;
  logic [WORD_W-1:0]          wdata_reg, wdata_next;
  logic                       switch_reg, switch_next;
  logic                       done_reg, done_next;

  logic              beat, flush_en, lane_empty, word_done;
  logic [WORD_W-1:0] word;

  // in_rdy is only ever high in FILL, so these also gate flush to FILL.
  assign beat     = in_vld && in_rdy_reg;
  assign flush_en = flush && in_rdy_reg;

  lane_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_lane_packer (
    .clk        (clk),
    .rst        (rst),
    .beat       (beat),
    .flush_en   (flush_en),
    .in_dat     (in_dat),
    .lane_empty (lane_empty),
    .word_done  (word_done),
    .word       (word)
  );

  always_comb begin
    state_next      = state_reg;
    addr_cnt_next   = addr_cnt_reg;
    wpb_next        = wpb_reg;
    fills_left_next = fills_left_reg;
    wen_next        = 1'b0;
    wadr_next       = wadr_reg;
    wdata_next      = wdata_reg;
    switch_next     = 1'b0;
    done_next       = 1'b0;
    consume         = 1'b0;

    case (state_reg)
      IDLE: begin
        // Jobs with a zero field are accepted and dropped.
        if (cfg_vld && cfg_rdy_reg &&
            (cfg_dat.words_per_bank != '0) && (cfg_dat.num_fills != '0)) begin
          wpb_next        = cfg_dat.words_per_bank;
          fills_left_next = cfg_dat.num_fills;
          addr_cnt_next   = '0;
          state_next      = FILL;
        end
      end

      FILL: begin
        if (word_done) begin
          wen_next      = 1'b1;
          wadr_next     = addr_cnt_reg[BANK_ADDR_WIDTH-1:0];
          wdata_next    = word;
          addr_cnt_next = addr_cnt_reg + ADDR_ONE;
          if ((addr_cnt_reg == wpb_reg - ADDR_ONE) || flush_en) begin
            state_next = SWAP;
          end
        end else if (flush_en && lane_empty && (addr_cnt_reg != '0)) begin
          // Nothing buffered but the bank has content: close it as is.
          state_next = SWAP;
        end
      end

      SWAP: begin
        if (credit_reg) begin
          consume         = 1'b1;
          switch_next     = 1'b1;
          addr_cnt_next   = '0;
          fills_left_next = fills_left_reg - FILL_ONE;
          if (fills_left_reg == FILL_ONE) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FILL;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // A release in the same cycle as a swap leaves the credit set.
    credit_next = bank_free ? 1'b1 : (consume ? 1'b0 : credit_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_cnt_reg   <= '0;
      wpb_reg        <= '0;
      fills_left_reg <= '0;
      credit_reg     <= 1'b1;
      cfg_rdy_reg    <= 1'b1;
      in_rdy_reg     <= 1'b0;
      wen_reg        <= 1'b0;
      wadr_reg       <= '0;
      wdata_reg      <= '0;
      switch_reg     <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_cnt_reg   <= addr_cnt_next;
      wpb_reg        <= wpb_next;
      fills_left_reg <= fills_left_next;
      credit_reg     <= credit_next;
      cfg_rdy_reg    <= (state_next == IDLE);
      in_rdy_reg     <= (state_next == FILL);
      wen_reg        <= wen_next;
      wadr_reg       <= wadr_next;
      wdata_reg      <= wdata_next;
      switch_reg     <= switch_next;
      done_reg       <= done_next;
    end
  end

  assign cfg_rdy      = cfg_rdy_reg;
  assign in_rdy       = in_rdy_reg;
  assign wen          = wen_reg;
  assign wadr         = wadr_reg;
  assign wdata        = wdata_reg;
  assign switch_banks = switch_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_stream_bank_packer.sv
module tb_stream_bank_packer;

  localparam int DW    = 16;
  localparam int LN    = 4;
  localparam int AW    = 8;
  localparam int FW    = 16;
  localparam int WW    = DW * LN;
  localparam int LIMIT = 200;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  pack_pkg::pack_cfg_t  cfg_dat;
  logic                 cfg_vld = 1'b0;
  logic                 cfg_rdy;
  logic [DW-1:0]        in_dat = '0;
  logic                 in_vld = 1'b0;
  logic                 in_rdy;
  logic                 flush = 1'b0;
  logic                 bank_free = 1'b0;
  logic                 wen;
  logic [AW-1:0]        wadr;
  logic [WW-1:0]        wdata;
  logic                 switch_banks;
  logic                 done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  stream_bank_packer #(
    .DATA_WIDTH      (DW),
    .LANES           (LN),
    .BANK_ADDR_WIDTH (AW),
    .FILL_CNT_WIDTH  (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_dat      (cfg_dat),
    .cfg_vld      (cfg_vld),
    .cfg_rdy      (cfg_rdy),
    .in_dat       (in_dat),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .flush        (flush),
    .bank_free    (bank_free),
    .wen          (wen),
    .wadr         (wadr),
    .wdata        (wdata),
    .switch_banks (switch_banks),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write / switch / done events, stamped with the cycle number.
  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    int            cyc;
  } wr_t;
  wr_t wr_q[$];
  int  sw_q[$];
  int  dn_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (wen)          wr_q.push_back('{wadr, wdata, cyc});
      if (switch_banks) sw_q.push_back(cyc);
      if (done)         dn_q.push_back(cyc);
    end
  end

  // Reference model: a fill's beats are cut into LANES-sized words (lane 0
  // first, tail zero padded) written at addresses 0,1,2,... of the bank.
  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  function automatic void model_fill(input logic [DW-1:0] b[$]);
    int n  = b.size();
    int nw = (n + LN - 1) / LN;
    logic [WW-1:0] w;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int l = 0; l < LN; l++) begin
        if (k * LN + l < n) w[l*DW +: DW] = b[k*LN + l];
      end
      exp_q.push_back('{AW'(k), w});
    end
  endfunction

  // ---------------- drivers (all called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_free();
    bank_free = 1'b1;
    @(negedge clk);
    bank_free = 1'b0;
  endtask

  task automatic drive_cfg(input int wpb, input int nf);
    int t = 0;
    cfg_dat.words_per_bank = (AW + 1)'(wpb);
    cfg_dat.num_fills      = FW'(nf);
    cfg_vld = 1'b1;
    while (!cfg_rdy && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    cfg_vld = 1'b0;
    checks++;
    if (t >= LIMIT) begin
      errors++;
      $display("FAIL cfg_handshake got cfg_rdy=0 for %0d cycles exp cfg_rdy=1", t);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int t = 0;
    in_dat = d;
    in_vld = 1'b1;
    while (!in_rdy && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    in_vld = 1'b0;
    checks++;
    if (t >= LIMIT) begin
      errors++;
      $display("FAIL beat_handshake got in_rdy=0 for %0d cycles exp in_rdy=1", t);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(2);
    checks++;
    if ({wen, switch_banks, done, in_rdy, cfg_rdy} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl got wen/sw/done/in_rdy/cfg_rdy=%b exp 00001",
               {wen, switch_banks, done, in_rdy, cfg_rdy});
    end
    checks++;
    if (wadr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_data got wadr=%0d wdata=%h exp 0 0", wadr, wdata);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (cfg_rdy !== 1'b1 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got cfg_rdy=%b in_rdy=%b exp 1 0", cfg_rdy, in_rdy);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] b[$];
    int wb = wr_q.size();
    int sb = sw_q.size();
    int db = dn_q.size();
    exp_q.delete();
    drive_cfg(4, 1);
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_rdy got %b exp 1", in_rdy);
    end
    for (int i = 1; i <= 16; i++) begin
      b.push_back(DW'(i));
      send_beat(DW'(i));
    end
    model_fill(b);
    idle(6);
    checks++;
    if (wr_q.size() - wb !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_wcount got %0d exp %0d", wr_q.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wb+i].addr !== exp_q[i].addr || wr_q[wb+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL basic_word%0d got adr=%0d data=%h exp adr=%0d data=%h", i,
                 wr_q[wb+i].addr, wr_q[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (sw_q.size() - sb !== 1 || dn_q.size() - db !== 1) begin
      errors++;
      $display("FAIL basic_sw_done got sw=%0d done=%0d exp 1 1", sw_q.size() - sb, dn_q.size() - db);
    end else begin
      checks++;
      if (sw_q[sb] !== wr_q[wr_q.size()-1].cyc + 1 || dn_q[db] !== sw_q[sb]) begin
        errors++;
        $display("FAIL basic_sw_timing got last_wen=%0d sw=%0d done=%0d exp sw=last_wen+1=done",
                 wr_q[wr_q.size()-1].cyc, sw_q[sb], dn_q[db]);
      end
    end
    checks++;
    if (cfg_rdy !== 1'b1 || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got cfg_rdy=%b in_rdy=%b exp 1 0", cfg_rdy, in_rdy);
    end
  endtask

  task automatic test_credit();
    logic [DW-1:0] b[$];
    logic [DW-1:0] d;
    int wb, sb, db;
    exp_q.delete();
    pulse_free();
    wb = wr_q.size();
    sb = sw_q.size();
    db = dn_q.size();
    drive_cfg(2, 3);
    for (int f = 0; f < 2; f++) begin
      b.delete();
      for (int i = 0; i < 8; i++) begin
        d = DW'($urandom);
        b.push_back(d);
        send_beat(d);
      end
      model_fill(b);
      idle(4);
    end
    idle(6);
    checks++;
    if (sw_q.size() - sb !== 1 || in_rdy !== 1'b0 || dn_q.size() - db !== 0) begin
      errors++;
      $display("FAIL credit_hold got sw=%0d in_rdy=%b done=%0d exp 1 0 0",
               sw_q.size() - sb, in_rdy, dn_q.size() - db);
    end
    pulse_free();
    idle(3);
    checks++;
    if (sw_q.size() - sb !== 2) begin
      errors++;
      $display("FAIL credit_release got sw=%0d exp 2", sw_q.size() - sb);
    end
    pulse_free();
    b.delete();
    for (int i = 0; i < 8; i++) begin
      d = DW'($urandom);
      b.push_back(d);
      send_beat(d);
    end
    model_fill(b);
    idle(6);
    checks++;
    if (wr_q.size() - wb !== exp_q.size()) begin
      errors++;
      $display("FAIL credit_wcount got %0d exp %0d", wr_q.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wb+i].addr !== exp_q[i].addr || wr_q[wb+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL credit_word%0d got adr=%0d data=%h exp adr=%0d data=%h", i,
                 wr_q[wb+i].addr, wr_q[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (sw_q.size() - sb !== 3 || dn_q.size() - db !== 1) begin
      errors++;
      $display("FAIL credit_sw_done got sw=%0d done=%0d exp 3 1", sw_q.size() - sb, dn_q.size() - db);
    end else begin
      checks++;
      if (dn_q[db] !== sw_q[sb+2]) begin
        errors++;
        $display("FAIL credit_done_timing got done=%0d exp %0d", dn_q[db], sw_q[sb+2]);
      end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] b[$];
    int wb, sb, db;
    exp_q.delete();
    pulse_free();
    wb = wr_q.size();
    sb = sw_q.size();
    db = dn_q.size();
    drive_cfg(4, 1);
    for (int i = 1; i <= 6; i++) begin
      b.push_back(DW'(i));
      send_beat(DW'(i));
    end
    model_fill(b);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(6);
    checks++;
    if (wr_q.size() - wb !== exp_q.size()) begin
      errors++;
      $display("FAIL flush_wcount got %0d exp %0d", wr_q.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wb+i].addr !== exp_q[i].addr || wr_q[wb+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL flush_word%0d got adr=%0d data=%h exp adr=%0d data=%h", i,
                 wr_q[wb+i].addr, wr_q[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (sw_q.size() - sb !== 1 || dn_q.size() - db !== 1) begin
      errors++;
      $display("FAIL flush_sw_done got sw=%0d done=%0d exp 1 1", sw_q.size() - sb, dn_q.size() - db);
    end else begin
      checks++;
      if (sw_q[sb] !== wr_q[wr_q.size()-1].cyc + 1) begin
        errors++;
        $display("FAIL flush_sw_timing got sw=%0d exp %0d", sw_q[sb], wr_q[wr_q.size()-1].cyc + 1);
      end
    end
  endtask

  task automatic test_flush_empty();
    logic [DW-1:0] b[$];
    logic [DW-1:0] d;
    int wb, sb, db;
    exp_q.delete();
    pulse_free();
    wb = wr_q.size();
    sb = sw_q.size();
    db = dn_q.size();
    drive_cfg(4, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(5);
    checks++;
    if (wr_q.size() - wb !== 0 || sw_q.size() - sb !== 0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty got wen=%0d sw=%0d in_rdy=%b exp 0 0 1",
               wr_q.size() - wb, sw_q.size() - sb, in_rdy);
    end
    for (int i = 0; i < 16; i++) begin
      d = DW'($urandom);
      b.push_back(d);
      send_beat(d);
    end
    model_fill(b);
    idle(6);
    checks++;
    if (wr_q.size() - wb !== exp_q.size() || dn_q.size() - db !== 1) begin
      errors++;
      $display("FAIL flush_empty_after got words=%0d done=%0d exp %0d 1",
               wr_q.size() - wb, dn_q.size() - db, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wb+i].addr !== exp_q[i].addr || wr_q[wb+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL flush_empty_word%0d got adr=%0d data=%h exp adr=%0d data=%h", i,
                 wr_q[wb+i].addr, wr_q[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] b0[$];
    logic [DW-1:0] b1[$];
    logic [DW-1:0] d;
    int wb, sb, db;
    exp_q.delete();
    pulse_free();
    wb = wr_q.size();
    sb = sw_q.size();
    db = dn_q.size();
    drive_cfg(8, 2);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (i == 40) pulse_free();
      d = DW'($urandom);
      if (i < 32) b0.push_back(d);
      else        b1.push_back(d);
      send_beat(d);
    end
    model_fill(b0);
    model_fill(b1);
    idle(8);
    checks++;
    if (wr_q.size() - wb !== exp_q.size()) begin
      errors++;
      $display("FAIL random_wcount got %0d exp %0d", wr_q.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wb+i].addr !== exp_q[i].addr || wr_q[wb+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL random_word%0d got adr=%0d data=%h exp adr=%0d data=%h", i,
                 wr_q[wb+i].addr, wr_q[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (sw_q.size() - sb !== 2 || dn_q.size() - db !== 1) begin
      errors++;
      $display("FAIL random_sw_done got sw=%0d done=%0d exp 2 1", sw_q.size() - sb, dn_q.size() - db);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] b[$];
    int wb, sb, db;
    exp_q.delete();
    drive_cfg(4, 1);
    for (int i = 1; i <= 3; i++) send_beat(DW'(i));
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wen, switch_banks, done, in_rdy, cfg_rdy} !== 5'b00001 || wadr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got wen/sw/done/in_rdy/cfg_rdy=%b wadr=%0d wdata=%h exp 00001 0 0",
               {wen, switch_banks, done, in_rdy, cfg_rdy}, wadr, wdata);
    end
    idle(2);
    checks++;
    if (wen !== 1'b0 || switch_banks !== 1'b0) begin
      errors++;
      $display("FAIL midreset_hold got wen=%b sw=%b exp 0 0", wen, switch_banks);
    end
    rst = 1'b0;
    idle(1);
    wb = wr_q.size();
    sb = sw_q.size();
    db = dn_q.size();
    drive_cfg(4, 1);
    for (int i = 1; i <= 16; i++) begin
      b.push_back(DW'(100 + i));
      send_beat(DW'(100 + i));
    end
    model_fill(b);
    idle(6);
    checks++;
    if (wr_q.size() - wb !== exp_q.size()) begin
      errors++;
      $display("FAIL midreset_wcount got %0d exp %0d", wr_q.size() - wb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[wb+i].addr !== exp_q[i].addr || wr_q[wb+i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL midreset_word%0d got adr=%0d data=%h exp adr=%0d data=%h", i,
                 wr_q[wb+i].addr, wr_q[wb+i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    checks++;
    if (sw_q.size() - sb !== 1 || dn_q.size() - db !== 1) begin
      errors++;
      $display("FAIL midreset_credit got sw=%0d done=%0d exp 1 1", sw_q.size() - sb, dn_q.size() - db);
    end
  endtask

  initial begin
    cfg_dat = '0;
    test_reset();
    test_basic();
    test_credit();
    test_flush();
    test_flush_empty();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got simulation still running exp finished");
    $fatal(1, "timeout");
  end

endmodule
